// File: rtl/par2ser_arb_pkg.sv
// Shared types and constants for the par2ser round-robin arbiter.
// Optional build macro: PAR2SER_ARB_CH0_PRIO_EN (channel 0 priority in the picker).
package par2ser_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam int BURST_W = 16;

    // Width of a channel index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/par2ser_rr_arb_rr_pick.sv
// Combinational rotate-priority encoder: first request at or after ptr, with wrap.
// PRIO_EN (driven from PAR2SER_ARB_CH0_PRIO_EN by the top) lets channel 0 win outright.
module rr_pick
    import par2ser_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter bit PRIO_EN = 1'b0,
    parameter int GW      = grant_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [GW-1:0]     ptr_i,
    output logic              hit_o,
    output logic [GW-1:0]     idx_o
);

    logic [GW:0] cand;

    // Walk offsets from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_CH)) begin
                cand = cand - (GW+1)'(NUM_CH);
            end
            if (req_i[cand[GW-1:0]]) begin
                hit_o = 1'b1;
                idx_o = cand[GW-1:0];
            end
        end
        if (PRIO_EN && req_i[0]) begin
            hit_o = 1'b1;
            idx_o = '0;
        end
    end

endmodule

// File: rtl/par2ser_rr_arb.sv
// Round-robin arbiter sharing one parallel-to-serial serializer among NUM_CH producers.
// Define PAR2SER_ARB_CH0_PRIO_EN to give channel 0 priority whenever a new grant is chosen.
module par2ser_rr_arb
    import par2ser_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PARWIDTH  = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH-1:0]            ch_last,
    input  logic [NUM_CH*PARWIDTH-1:0]   ch_data,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic                         par_valid,
    input  logic                         par_ready,
    output logic [PARWIDTH-1:0]          par_din,
    output logic                         grant_valid,
    output logic [grant_w(NUM_CH)-1:0]   grant_id,
    output logic [BURST_W-1:0]           burst_cnt
);

    localparam int GW = grant_w(NUM_CH);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

`ifdef PAR2SER_ARB_CH0_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      gid_q, gid_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic               pick_hit;
    logic [GW-1:0]      pick_idx;
    logic               hs;
    logic               release_c;
    logic [PARWIDTH-1:0] ch_word [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_word
        assign ch_word[i] = ch_data[i*PARWIDTH +: PARWIDTH];
    end

    rr_pick #(
        .NUM_CH  (NUM_CH),
        .PRIO_EN (PRIO_EN),
        .GW      (GW)
    ) u_pick (
        .req_i (ch_valid),
        .ptr_i (ptr_q),
        .hit_o (pick_hit),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            burst_q <= burst_d;
        end
    end

    assign hs        = par_valid && par_ready;
    assign release_c = hs && (ch_last[gid_q] || (burst_q == BURST_LAST));

    // Pointer only moves on release, so a grant held through a stalled owner keeps fairness intact.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    gid_d   = pick_idx;
                    burst_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (release_c) begin
                    state_d = IDLE;
                    burst_d = '0;
                    ptr_d   = (gid_q == GW'(NUM_CH - 1)) ? '0 : gid_q + GW'(1);
                end else if (hs) begin
                    burst_d = burst_q + BURST_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        par_valid = 1'b0;
        par_din   = '0;
        ch_ready  = '0;
        if (state_q == XFER) begin
            par_valid       = ch_valid[gid_q];
            par_din         = ch_word[gid_q];
            ch_ready[gid_q] = par_ready;
        end
    end

    assign grant_valid = (state_q == XFER);
    assign grant_id    = gid_q;
    assign burst_cnt   = burst_q;

endmodule

// File: tb/tb_par2ser_rr_arb.sv
// Scoreboard bench for par2ser_rr_arb (NUM_CH=4, BURST_MAX=4).
// Expected grant order depends on PAR2SER_ARB_CH0_PRIO_EN, mirrored here.
module tb_par2ser_rr_arb;

    localparam int NUM_CH = 4;
    localparam int PW     = 32;
    localparam int BM     = 4;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_last;
    logic [NUM_CH*PW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_ready;
    logic                 par_valid;
    logic                 par_ready;
    logic [PW-1:0]        par_din;
    logic                 grant_valid;
    logic [1:0]           grant_id;
    logic [15:0]          burst_cnt;

    typedef struct {
        int          ch;
        logic [31:0] data;
        int          bc;
        int          gap;
    } exp_t;

    exp_t        expQ [$];
    logic [32:0] chq [NUM_CH][$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lastHs = 0;

    par2ser_rr_arb #(
        .NUM_CH    (NUM_CH),
        .PARWIDTH  (PW),
        .BURST_MAX (BM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_last     (ch_last),
        .ch_data     (ch_data),
        .ch_ready    (ch_ready),
        .par_valid   (par_valid),
        .par_ready   (par_ready),
        .par_din     (par_din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_cnt   (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int ch, input logic [31:0] data, input logic last);
        chq[ch].push_back({last, data});
    endtask

    task automatic expectWord(input int ch, input logic [31:0] data, input int bc, input int gap);
        exp_t e;
        e.ch = ch; e.data = data; e.bc = bc; e.gap = gap;
        expQ.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            waitCycle();
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
    endtask

    // Producer model: each channel presents the head of its queue and pops it once accepted.
    initial begin
        logic [NUM_CH-1:0] acc;
        logic [32:0]       tmp;
        ch_valid = '0;
        ch_last  = '0;
        ch_data  = '0;
        forever begin
            @(negedge clk);
            acc = ch_valid & ch_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[i]) tmp = chq[i].pop_front();
                if (chq[i].size() > 0) begin
                    tmp                 = chq[i][0];
                    ch_valid[i]         = 1'b1;
                    ch_last[i]          = tmp[32];
                    ch_data[i*PW +: PW] = tmp[31:0];
                end else begin
                    ch_valid[i]         = 1'b0;
                    ch_last[i]          = 1'b0;
                    ch_data[i*PW +: PW] = '0;
                end
            end
        end
    end

    // Monitor: every serializer handshake is matched against the next expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && par_valid && par_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWord: got 0x%0h from ch %0d, expected none", par_din, grant_id);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("grantId", 64'(grant_id), 64'(e.ch));
                    checkOutput("parDin", 64'(par_din), 64'(e.data));
                    checkOutput("chReady", 64'(ch_ready), 64'(4'b0001 << e.ch));
                    checkOutput("burstCnt", 64'(burst_cnt), 64'(e.bc));
                    if (e.gap >= 0) checkOutput("hsGap", 64'(cyc - lastHs), 64'(e.gap));
                end
                lastHs = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        par_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        waitCycle();
        checkOutput("rstGrantValid", 64'(grant_valid), 64'd0);
        checkOutput("rstGrantId", 64'(grant_id), 64'd0);
        checkOutput("rstBurstCnt", 64'(burst_cnt), 64'd0);
        checkOutput("rstParValid", 64'(par_valid), 64'd0);
        checkOutput("rstChReady", 64'(ch_ready), 64'd0);
        checkOutput("rstParDin", 64'(par_din), 64'd0);

        // All four channels request, 1-word packets: 0,1,2,3,0 with one idle cycle between.
        applyStimulus(0, 32'hC000_000A, 1'b1);
        applyStimulus(0, 32'hC000_000B, 1'b1);
        applyStimulus(1, 32'hC000_0001, 1'b1);
        applyStimulus(2, 32'hC000_0002, 1'b1);
        applyStimulus(3, 32'hC000_0003, 1'b1);
        expectWord(0, 32'hC000_000A, 0, -1);
        expectWord(1, 32'hC000_0001, 0, 2);
        expectWord(2, 32'hC000_0002, 0, 2);
        expectWord(3, 32'hC000_0003, 0, 2);
        expectWord(0, 32'hC000_000B, 0, 2);
        waitDrain(60);

        // Single channel 1, three words with last on the third.
        applyStimulus(1, 32'h1111_0001, 1'b0);
        applyStimulus(1, 32'h1111_0002, 1'b0);
        applyStimulus(1, 32'h1111_0003, 1'b1);
        expectWord(1, 32'h1111_0001, 0, -1);
        expectWord(1, 32'h1111_0002, 1, 1);
        expectWord(1, 32'h1111_0003, 2, 1);
        waitCycle();
        checkOutput("s1NotYetGranted", 64'(grant_valid), 64'd0);
        waitCycle();
        checkOutput("s1GrantValid", 64'(grant_valid), 64'd1);
        checkOutput("s1GrantId", 64'(grant_id), 64'd1);
        checkOutput("s1BurstStart", 64'(burst_cnt), 64'd0);
        waitDrain(40);
        checkOutput("s1Released", 64'(grant_valid), 64'd0);

        // ptr is now 2: channel 3 must beat channel 0.
        applyStimulus(0, 32'hB000_0000, 1'b1);
        applyStimulus(3, 32'hB000_0003, 1'b1);
        expectWord(3, 32'hB000_0003, 0, -1);
        expectWord(0, 32'hB000_0000, 0, 2);
        waitDrain(40);

        // Channel 2 streams without last; burst limit releases it, channel 3 gets a turn.
        for (int i = 0; i < 10; i++) applyStimulus(2, 32'hD000_0000 + 32'(i), 1'b0);
        applyStimulus(3, 32'hE000_0003, 1'b1);
        for (int i = 0; i < 4; i++) expectWord(2, 32'hD000_0000 + 32'(i), i, (i == 0) ? -1 : 1);
        expectWord(3, 32'hE000_0003, 0, 2);
        for (int i = 4; i < 8; i++) expectWord(2, 32'hD000_0000 + 32'(i), i - 4, (i == 4) ? 2 : 1);
        expectWord(2, 32'hD000_0008, 0, 2);
        expectWord(2, 32'hD000_0009, 1, 1);
        waitDrain(80);
        waitCycle();
        checkOutput("s3HeldGrant", 64'(grant_valid), 64'd1);
        checkOutput("s3HeldId", 64'(grant_id), 64'd2);
        checkOutput("s3HeldParValid", 64'(par_valid), 64'd0);
        checkOutput("s3HeldBurst", 64'(burst_cnt), 64'd2);
        applyStimulus(2, 32'hD000_000A, 1'b1);
        expectWord(2, 32'hD000_000A, 2, -1);
        waitDrain(20);

        // ptr is 3; channel 1 sends two words, then reset lands mid-grant.
        applyStimulus(1, 32'h4000_0000, 1'b0);
        applyStimulus(1, 32'h4000_0001, 1'b0);
        expectWord(1, 32'h4000_0000, 0, -1);
        expectWord(1, 32'h4000_0001, 1, 1);
        waitDrain(30);
        par_ready = 1'b0;
        applyStimulus(1, 32'h4000_0002, 1'b1);
        expectWord(1, 32'h4000_0002, 0, -1);
        waitCycle();
        waitCycle();
        checkOutput("preRstParValid", 64'(par_valid), 64'd1);
        checkOutput("preRstBurst", 64'(burst_cnt), 64'd2);
        checkOutput("preRstGrantId", 64'(grant_id), 64'd1);
        rst = 1'b1;
        applyStimulus(3, 32'h5000_0003, 1'b1);
        expectWord(3, 32'h5000_0003, 0, 2);
        #1;
        checkOutput("asyncRstParValid", 64'(par_valid), 64'd0);
        checkOutput("asyncRstChReady", 64'(ch_ready), 64'd0);
        checkOutput("asyncRstParDin", 64'(par_din), 64'd0);
        checkOutput("asyncRstGrantValid", 64'(grant_valid), 64'd0);
        checkOutput("asyncRstGrantId", 64'(grant_id), 64'd0);
        checkOutput("asyncRstBurst", 64'(burst_cnt), 64'd0);
        waitCycle();
        waitCycle();
        rst       = 1'b0;
        par_ready = 1'b1;
        waitDrain(30);

        // ptr is 0; par_ready pulses once every 5 cycles while channel 1 owns the grant.
        par_ready = 1'b0;
        applyStimulus(1, 32'hF000_0000, 1'b0);
        applyStimulus(1, 32'hF000_0001, 1'b0);
        applyStimulus(1, 32'hF000_0002, 1'b1);
        expectWord(1, 32'hF000_0000, 0, -1);
        expectWord(1, 32'hF000_0001, 1, 5);
        expectWord(1, 32'hF000_0002, 2, 5);
        for (int i = 0; i < 15; i++) begin
            par_ready = ((i % 5) == 4);
            if (i == 2) begin
                applyStimulus(3, 32'h6000_0003, 1'b1);
                expectWord(3, 32'h6000_0003, 0, -1);
            end
            if (i == 3) begin
                checkOutput("pulseIdleChReady", 64'(ch_ready), 64'd0);
                checkOutput("pulseIdleParValid", 64'(par_valid), 64'd1);
                checkOutput("pulseIdleParDin", 64'(par_din), 64'hF000_0000);
                checkOutput("pulseIdleGrantId", 64'(grant_id), 64'd1);
            end
            waitCycle();
        end
        par_ready = 1'b1;
        waitDrain(30);

        // Bring ptr to 2, then ch0 and ch2 request together.
        applyStimulus(1, 32'h7000_0001, 1'b1);
        expectWord(1, 32'h7000_0001, 0, -1);
        waitDrain(20);
        applyStimulus(0, 32'h8000_0000, 1'b1);
        applyStimulus(2, 32'h8000_0002, 1'b1);
`ifdef PAR2SER_ARB_CH0_PRIO_EN
        expectWord(0, 32'h8000_0000, 0, -1);
        expectWord(2, 32'h8000_0002, 0, 2);
`else
        expectWord(2, 32'h8000_0002, 0, -1);
        expectWord(0, 32'h8000_0000, 0, 2);
`endif
        waitDrain(30);
        waitCycle();
        checkOutput("finalIdle", 64'(grant_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
